pick_history_scan: RTL and testbench
====================================

Name: pick_history_scan

Overview:
- Downstream consumer of the unique-number selector.
- Captures each newly selected 3-bit number, in pick order, into an 8-entry history.
- Drives a time-multiplexed 8-digit seven-segment scan of the history: digit value plus one-hot anode enable; the value feeds the existing seven_seg decoder.
- Flags duplicate and overflow picks.
- Replays the history over a valid/ready stream for logging or UART.

Parameters:
- SCAN_DIV, 50000: clock cycles each digit stays lit; legal range 1 to 2^20-1.
- CHECK_DUP, 1: 1 enables duplicate detection; 0 ties dup_err low.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- done  in  1  one-cycle pulse from selector; selected_number valid this cycle
- selected_number  in  3  number chosen by selector
- replay_start  in  1  request replay of stored history
- out_ready  in  1  replay consumer ready
- out_valid  out  1  replay entry valid
- out_data  out  3  replay entry value
- replay_busy  out  1  high while in REPLAY state
- replay_done  out  1  one-cycle pulse after last entry accepted
- digit  out  4  value for seven_seg, {1'b0, entry}
- an  out  8  one-hot digit enable, active-high; bit i = history entry i
- count  out  4  entries stored, 0..8
- full  out  1  count == 8
- dup_err  out  1  sticky: a captured value was already present
- ovf_err  out  1  sticky: done arrived while full

Behaviour:
- Reset: all outputs 0; history, seen mask, pointers and scan counters cleared; state IDLE.
- Reset mid-replay or mid-scan aborts immediately. No replay_done pulse is issued on abort.

Capture:
- On done && !full: mem[count] <= selected_number; count increments; seen[selected_number] set.
- Capture is visible on count, full and scan on the next cycle.
- If CHECK_DUP and seen[selected_number] is already 1 at capture, dup_err sets. The value is still stored.
- done && full: nothing stored; ovf_err sets. Both error flags clear only on rst.
- done is sampled only when high; back-to-back done pulses are each captured.

Scan:
- A divider counts 0..SCAN_DIV-1.
- On terminal count, scan_idx advances 0→1→…→7→0 (wraps).
- digit = {1'b0, mem[scan_idx]} registered.
- an = (1 << scan_idx) if scan_idx < count, else 8'h00 (blank unpopulated digits).
- digit and an update in the same cycle; 1-cycle latency from scan_idx.
- Scanning runs continuously and is unaffected by replay.

Replay FSM, states IDLE and REPLAY:
- IDLE: replay_start && count != 0 → REPLAY.
  - rd_idx <= 0; len <= count as of this cycle. A capture in the same cycle is not included.
- IDLE: replay_start with count == 0 is ignored.
- REPLAY: out_valid = 1, out_data = mem[rd_idx], replay_busy = 1.
  - On out_valid && out_ready: if rd_idx == len-1, go to IDLE and pulse replay_done for 1 cycle; otherwise rd_idx increments.
  - out_data is held stable while out_valid && !out_ready.
  - replay_start during REPLAY is ignored.
  - Captures during REPLAY proceed normally. They write only indices >= len, so replay data is undisturbed.
- Throughput: one entry per cycle with out_ready held high. First out_valid appears the cycle after replay_start.
- Unreachable FSM encoding returns to IDLE.

Test Plan:
- Reset, then 8 done pulses with values 5,2,7,0,3,6,1,4 → count=8, full=1, dup_err=0, ovf_err=0; mem holds that order.
- SCAN_DIV=4, 3 entries 5,2,7 → an cycles 01,02,04 for 4 cycles each, then 00 for 20 cycles, then repeats; digit shows 5,2,7 during the matching enables.
- Pick values 3, 3 → dup_err=1 after the second capture, count=2. A 9th done after filling → ovf_err=1, count stays 8.
- Store 4 entries; replay_start with out_ready toggling 1,0,1,1,0,1 → outputs the 4 values in order, data held during stalls, replay_done pulses once after the 4th handshake.
- Same-cycle replay_start and done with count=2 → replay emits exactly 2 entries; count=3 afterward. replay_start with count=0 → out_valid stays 0.
- Assert rst during REPLAY after 1 accepted entry → next cycle out_valid=0, count=0, an=0, no replay_done pulse.

Source files
------------

// File: rtl/pick_history_scan_if.sv
// pick_history_scan_if
//   Bundles the selector handshake (done / selected_number) and the replay
//   valid/ready stream of pick_history_scan into one interface.
//   master : the side that issues picks and consumes replay entries.
//   slave  : pick_history_scan itself.
// Signals:
//   done            one-cycle pulse, selected_number valid this cycle
//   selected_number 3-bit number chosen by the selector
//   replay_start    request a replay of the stored history
//   out_ready       replay consumer ready
//   out_valid       replay entry valid
//   out_data        replay entry value
//   replay_busy     high while a replay is in progress
//   replay_done     one-cycle pulse after the last entry was accepted
interface pick_history_scan_if;
  logic       done;
  logic [2:0] selected_number;
  logic       replay_start;
  logic       out_ready;
  logic       out_valid;
  logic [2:0] out_data;
  logic       replay_busy;
  logic       replay_done;

  modport master (
    output done, selected_number, replay_start, out_ready,
    input  out_valid, out_data, replay_busy, replay_done
  );

  modport slave (
    input  done, selected_number, replay_start, out_ready,
    output out_valid, out_data, replay_busy, replay_done
  );
endinterface

// File: rtl/pick_history_scan.sv
// pick_history_scan
//   Records each number picked by the unique-number selector into an
//   8-entry history (in pick order), scans that history onto an 8-digit
//   seven-segment display, flags duplicate and overflow picks, and can
//   replay the stored history over a valid/ready stream.
// Ports:
//   clk, rst  system clock, synchronous active-high reset
//   bus       pick handshake and replay stream (slave side)
//   digit     {1'b0, entry} for the seven_seg decoder
//   an        one-hot active-high digit enable, blank when entry unused
//   count     number of stored entries, 0..8
//   full      count == 8
//   dup_err   sticky: a captured value was already in the history
//   ovf_err   sticky: a pick arrived while the history was full
module pick_history_scan #(
  parameter int SCAN_DIV  = 50000,
  parameter int CHECK_DUP = 1
) (
  input  logic                clk,
  input  logic                rst,
  pick_history_scan_if.slave  bus,
  output logic [3:0]          digit,
  output logic [7:0]          an,
  output logic [3:0]          count,
  output logic                full,
  output logic                dup_err,
  output logic                ovf_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REPLAY = 2'd1
  } state_t;

  localparam logic [19:0] DIV_LAST = 20'(SCAN_DIV - 1);

  logic [2:0]  mem [8];
  logic [7:0]  seen;
  logic        capture;
  logic [19:0] div_cnt;
  logic [2:0]  scan_idx;

  state_t      state, state_next;
  logic [2:0]  rd_idx, rd_idx_next;
  logic [3:0]  len, len_next;
  logic        replay_done_q, replay_done_next;

  assign full    = (count == 4'd8);
  assign capture = bus.done && !full;

  // History capture and error flags. Entries are written in pick order,
  // so an entry below the replay length is never rewritten until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= 4'd0;
      seen    <= 8'h00;
      dup_err <= 1'b0;
      ovf_err <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        mem[i] <= 3'd0;
      end
    end else begin
      if (capture) begin
        mem[count[2:0]]              <= bus.selected_number;
        count                        <= count + 4'd1;
        seen[bus.selected_number]    <= 1'b1;
        if ((CHECK_DUP != 0) && seen[bus.selected_number]) begin
          dup_err <= 1'b1;
        end
      end
      if (bus.done && full) begin
        ovf_err <= 1'b1;
      end
    end
  end

  // Display scan: each digit stays lit for SCAN_DIV cycles; digit and an
  // are registered together so they change on the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt  <= 20'd0;
      scan_idx <= 3'd0;
      digit    <= 4'd0;
      an       <= 8'h00;
    end else begin
      if (div_cnt == DIV_LAST) begin
        div_cnt  <= 20'd0;
        scan_idx <= scan_idx + 3'd1;
      end else begin
        div_cnt <= div_cnt + 20'd1;
      end
      digit <= {1'b0, mem[scan_idx]};
      an    <= ({1'b0, scan_idx} < count) ? (8'd1 << scan_idx) : 8'h00;
    end
  end

  // Replay FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      rd_idx        <= 3'd0;
      len           <= 4'd0;
      replay_done_q <= 1'b0;
    end else begin
      state         <= state_next;
      rd_idx        <= rd_idx_next;
      len           <= len_next;
      replay_done_q <= replay_done_next;
    end
  end

  // Replay FSM next state. The length is latched from count before any
  // same-cycle capture lands, so a simultaneous pick is not replayed.
  always_comb begin
    state_next       = state;
    rd_idx_next      = rd_idx;
    len_next         = len;
    replay_done_next = 1'b0;
    case (state)
      IDLE: begin
        if (bus.replay_start && (count != 4'd0)) begin
          state_next  = REPLAY;
          rd_idx_next = 3'd0;
          len_next    = count;
        end
      end
      REPLAY: begin
        if (bus.out_ready) begin
          if ({1'b0, rd_idx} == (len - 4'd1)) begin
            state_next       = IDLE;
            replay_done_next = 1'b1;
          end else begin
            rd_idx_next = rd_idx + 3'd1;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.out_valid   = (state == REPLAY);
  assign bus.replay_busy = (state == REPLAY);
  assign bus.out_data    = mem[rd_idx];
  assign bus.replay_done = replay_done_q;

endmodule

// File: tb/tb_pick_history_scan.sv
// tb_pick_history_scan
//   Drives pick_history_scan (SCAN_DIV = 4) with directed scenarios and a
//   randomized phase, and compares every output each cycle against a
//   queue-based model of the pick history, display scan and replay.
module tb_pick_history_scan;
  localparam int SCAN_DIV = 4;

  logic       clk;
  logic       rst;
  logic [3:0] digit;
  logic [7:0] an;
  logic [3:0] count;
  logic       full;
  logic       dup_err;
  logic       ovf_err;

  pick_history_scan_if bus ();

  pick_history_scan #(
    .SCAN_DIV  (SCAN_DIV),
    .CHECK_DUP (1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .digit   (digit),
    .an      (an),
    .count   (count),
    .full    (full),
    .dup_err (dup_err),
    .ovf_err (ovf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  bit checking   = 0;

  // Model state
  logic [2:0] hist  [$];
  logic [2:0] rep_q [$];
  bit         rep_active;
  bit [7:0]   m_seen;
  bit         m_dup, m_ovf, m_done;
  logic [3:0] m_digit;
  logic [7:0] m_an;
  int         k;
  int         m_idx;

  // Observed replay traffic
  logic [2:0] got [$];
  int         done_pulses = 0;
  bit         prev_valid  = 0;
  logic [2:0] prev_data;

  task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: evaluated from the pre-edge model state and the inputs seen at
  // this edge. The display shows the entry chosen by the number of cycles
  // elapsed since reset; the replay is a snapshot of the history.
  always @(posedge clk) begin
    if (rst) begin
      hist.delete();
      rep_q.delete();
      rep_active = 0;
      m_seen     = 8'h00;
      m_dup      = 0;
      m_ovf      = 0;
      m_done     = 0;
      m_digit    = 4'd0;
      m_an       = 8'h00;
      k          = 0;
    end else begin
      m_idx   = (k / SCAN_DIV) % 8;
      m_an    = (m_idx < hist.size()) ? 8'(1 << m_idx) : 8'h00;
      m_digit = (m_idx < hist.size()) ? {1'b0, hist[m_idx]} : 4'd0;
      k++;
      m_done = 0;
      if (rep_active) begin
        if (bus.out_ready) begin
          void'(rep_q.pop_front());
          if (rep_q.size() == 0) begin
            rep_active = 0;
            m_done     = 1;
          end
        end
      end else if (bus.replay_start && hist.size() != 0) begin
        rep_q      = hist;
        rep_active = 1;
      end
      if (bus.done) begin
        if (hist.size() < 8) begin
          if (m_seen[bus.selected_number]) m_dup = 1;
          m_seen[bus.selected_number] = 1;
          hist.push_back(bus.selected_number);
        end else begin
          m_ovf = 1;
        end
      end
    end
  end

  // Per-cycle compare, just after the edge; also logs accepted replay
  // entries (valid held from before the edge, ready still at edge value).
  always @(posedge clk) begin
    #1;
    if (checking) begin
      check_output("out_valid",   8'(bus.out_valid),   8'(rep_active));
      check_output("replay_busy", 8'(bus.replay_busy), 8'(rep_active));
      if (rep_active) check_output("out_data", 8'(bus.out_data), 8'(rep_q[0]));
      check_output("replay_done", 8'(bus.replay_done), 8'(m_done));
      check_output("count",       8'(count),           8'(hist.size()));
      check_output("full",        8'(full),            8'(hist.size() == 8));
      check_output("dup_err",     8'(dup_err),         8'(m_dup));
      check_output("ovf_err",     8'(ovf_err),         8'(m_ovf));
      check_output("digit",       8'(digit),           8'(m_digit));
      check_output("an",          an,                  m_an);
      if (rst) begin
        prev_valid = 0;
      end else begin
        if (prev_valid && bus.out_ready) got.push_back(prev_data);
        if (bus.replay_done) done_pulses++;
        prev_valid = bus.out_valid;
        prev_data  = bus.out_data;
      end
    end
  end

  // One cycle of stimulus: set at a falling edge, held through the next
  // rising edge, returns at the following falling edge.
  task automatic apply_stimulus(input logic d, input logic [2:0] v, input logic rs, input logic rdy);
    bus.done            = d;
    bus.selected_number = v;
    bus.replay_start    = rs;
    bus.out_ready       = rdy;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    apply_stimulus(1'b0, 3'd0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 3'd0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 3'd0, 1'b0, 1'b1);
  endtask

  logic [2:0] order8 [8] = '{3'd5, 3'd2, 3'd7, 3'd0, 3'd3, 3'd6, 3'd1, 3'd4};
  logic [2:0] vals4  [4] = '{3'd1, 3'd6, 3'd2, 3'd5};
  logic       rdy6   [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    int base_g;
    int base_d;
    rst = 1'b1;
    bus.done = 1'b0; bus.selected_number = 3'd0; bus.replay_start = 1'b0; bus.out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checking = 1;
    rst = 1'b0;

    // Reset state
    check_output("rst_count", 8'(count), 8'd0);
    check_output("rst_an", an, 8'h00);
    check_output("rst_valid", 8'(bus.out_valid), 8'd0);

    // Fill with 5,2,7,0,3,6,1,4 then replay all of it
    for (int i = 0; i < 8; i++) apply_stimulus(1'b1, order8[i], 1'b0, 1'b0);
    idle(1);
    check_output("fill_count", 8'(count), 8'd8);
    check_output("fill_full", 8'(full), 8'd1);
    check_output("fill_dup", 8'(dup_err), 8'd0);
    check_output("fill_ovf", 8'(ovf_err), 8'd0);
    base_g = got.size();
    apply_stimulus(1'b0, 3'd0, 1'b1, 1'b0);
    idle(10);
    check_output("fill_replay_len", 8'(got.size() - base_g), 8'd8);
    for (int i = 0; i < 8; i++)
      if (base_g + i < got.size()) check_output("fill_order", 8'(got[base_g + i]), 8'(order8[i]));

    // Scan with 3 entries 5,2,7
    do_reset();
    apply_stimulus(1'b1, 3'd5, 1'b0, 1'b0);
    apply_stimulus(1'b1, 3'd2, 1'b0, 1'b0);
    apply_stimulus(1'b1, 3'd7, 1'b0, 1'b0);
    idle(3);
    check_output("scan_an_k6", an, 8'h02);
    check_output("scan_digit_k6", 8'(digit), 8'd2);
    idle(40);

    // Duplicate and overflow
    do_reset();
    apply_stimulus(1'b1, 3'd3, 1'b0, 1'b0);
    apply_stimulus(1'b1, 3'd3, 1'b0, 1'b0);
    check_output("dup_flag", 8'(dup_err), 8'd1);
    check_output("dup_count", 8'(count), 8'd2);
    for (int i = 0; i < 6; i++) apply_stimulus(1'b1, 3'(i), 1'b0, 1'b0);
    apply_stimulus(1'b1, 3'd7, 1'b0, 1'b0);
    check_output("ovf_flag", 8'(ovf_err), 8'd1);
    check_output("ovf_count", 8'(count), 8'd8);

    // Replay of 4 entries with stalling consumer
    do_reset();
    for (int i = 0; i < 4; i++) apply_stimulus(1'b1, vals4[i], 1'b0, 1'b0);
    base_g = got.size();
    base_d = done_pulses;
    apply_stimulus(1'b0, 3'd0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) apply_stimulus(1'b0, 3'd0, 1'b0, rdy6[i]);
    idle(3);
    check_output("stall_len", 8'(got.size() - base_g), 8'd4);
    for (int i = 0; i < 4; i++)
      if (base_g + i < got.size()) check_output("stall_data", 8'(got[base_g + i]), 8'(vals4[i]));
    check_output("stall_done_pulses", 8'(done_pulses - base_d), 8'd1);

    // Same-cycle replay_start and capture
    do_reset();
    apply_stimulus(1'b1, 3'd4, 1'b0, 1'b0);
    apply_stimulus(1'b1, 3'd0, 1'b0, 1'b0);
    base_g = got.size();
    apply_stimulus(1'b1, 3'd7, 1'b1, 1'b1);
    idle(5);
    check_output("same_len", 8'(got.size() - base_g), 8'd2);
    check_output("same_count", 8'(count), 8'd3);

    // replay_start with empty history
    do_reset();
    apply_stimulus(1'b0, 3'd0, 1'b1, 1'b1);
    check_output("empty_valid", 8'(bus.out_valid), 8'd0);

    // Reset during replay after one accepted entry
    do_reset();
    apply_stimulus(1'b1, 3'd2, 1'b0, 1'b0);
    apply_stimulus(1'b1, 3'd6, 1'b0, 1'b0);
    apply_stimulus(1'b0, 3'd0, 1'b1, 1'b0);
    apply_stimulus(1'b0, 3'd0, 1'b0, 1'b1);
    base_d = done_pulses;
    rst = 1'b1;
    apply_stimulus(1'b0, 3'd0, 1'b0, 1'b1);
    rst = 1'b0;
    check_output("abort_valid", 8'(bus.out_valid), 8'd0);
    check_output("abort_count", 8'(count), 8'd0);
    check_output("abort_an", an, 8'h00);
    idle(3);
    check_output("abort_no_done", 8'(done_pulses - base_d), 8'd0);

    // Randomized phase
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) rst = 1'b1;
      else rst = 1'b0;
      apply_stimulus(($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)),
                     ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)));
    end
    rst = 1'b0;
    idle(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
